// File: rtl/operand_fetch.sv
// Operand fetch: 32x32 register file, busy scoreboard, registered operand output stage.
// Optional macro OF_BYPASS_EN forwards a same-cycle writeback into the fetched operands.
module operand_fetch (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  rs_addr,
  input  logic [4:0]  rt_addr,
  input  logic        rs_used,
  input  logic        rt_used,
  input  logic [4:0]  dest_addr,
  input  logic        dest_en,
  input  logic        reg_write_to_file,
  input  logic [4:0]  reg_write_addr,
  input  logic [31:0] reg_write_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] rs_data,
  output logic [31:0] rt_data,
  output logic [4:0]  out_dest_addr,
  output logic        out_dest_en,
  output logic        hazard
);

  logic [31:0] r_regs [32];
  logic [31:0] r_busy;
  logic        r_out_valid;
  logic [31:0] r_rs_data;
  logic [31:0] r_rt_data;
  logic [4:0]  r_dest_addr;
  logic        r_dest_en;

  logic        w_wb;
  logic [31:0] w_wb_mask;
  logic [31:0] w_set_mask;
  logic [31:0] w_busy_eff;
  logic [31:0] w_rs_val;
  logic [31:0] w_rt_val;
  logic        w_accept;

  assign w_wb      = reg_write_to_file && (reg_write_addr != 5'd0);
  assign w_wb_mask = w_wb ? (32'd1 << reg_write_addr) : 32'd0;

`ifdef OF_BYPASS_EN
  // A register being written back this cycle is already resolved.
  assign w_busy_eff = r_busy & ~w_wb_mask;
  assign w_rs_val   = (w_wb && (reg_write_addr == rs_addr)) ? reg_write_data : r_regs[rs_addr];
  assign w_rt_val   = (w_wb && (reg_write_addr == rt_addr)) ? reg_write_data : r_regs[rt_addr];
`else
  assign w_busy_eff = r_busy;
  assign w_rs_val   = r_regs[rs_addr];
  assign w_rt_val   = r_regs[rt_addr];
`endif

  assign hazard   = in_valid && ((rs_used && w_busy_eff[rs_addr]) ||
                                 (rt_used && w_busy_eff[rt_addr]) ||
                                 (dest_en && w_busy_eff[dest_addr]));
  assign in_ready = !stall && !hazard && (!r_out_valid || out_ready);
  assign w_accept = in_valid && in_ready;

  assign w_set_mask = (w_accept && dest_en && (dest_addr != 5'd0)) ?
                      (32'd1 << dest_addr) : 32'd0;

  // Register file writes ignore stall; r0 is never written so it stays zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= 32'd0;
    end else if (w_wb) begin
      r_regs[reg_write_addr] <= reg_write_data;
    end
  end

  // Set is applied after clear so a same-cycle set wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy <= 32'd0;
    end else begin
      r_busy <= ((r_busy & ~w_wb_mask) | w_set_mask) & 32'hFFFF_FFFE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_valid <= 1'b0;
      r_rs_data   <= 32'd0;
      r_rt_data   <= 32'd0;
      r_dest_addr <= 5'd0;
      r_dest_en   <= 1'b0;
    end else if (!stall) begin
      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_rs_data   <= w_rs_val;
        r_rt_data   <= w_rt_val;
        r_dest_addr <= dest_addr;
        r_dest_en   <= dest_en;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid     = r_out_valid;
  assign rs_data       = r_rs_data;
  assign rt_data       = r_rt_data;
  assign out_dest_addr = r_dest_addr;
  assign out_dest_en   = r_dest_en;

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: directed scenarios plus randomized traffic
// compared every cycle against a behavioural scoreboard/register-file model.
module tb_operand_fetch;

`ifdef OF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk, rst, stall, in_valid, in_ready;
  logic [4:0]  rs_addr, rt_addr, dest_addr, reg_write_addr, out_dest_addr;
  logic        rs_used, rt_used, dest_en, reg_write_to_file;
  logic [31:0] reg_write_data, rs_data, rt_data;
  logic        out_valid, out_ready, out_dest_en, hazard;

  int n_cmp = 0;
  int n_bad = 0;

  // model state
  logic [31:0] m_mem [32];
  bit          m_pend [32];
  bit          m_ov, m_de;
  logic [31:0] m_rs, m_rt;
  logic [4:0]  m_da;

  operand_fetch dut (
    .clk(clk), .rst(rst), .stall(stall), .in_valid(in_valid), .in_ready(in_ready),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_used(rs_used), .rt_used(rt_used),
    .dest_addr(dest_addr), .dest_en(dest_en), .reg_write_to_file(reg_write_to_file),
    .reg_write_addr(reg_write_addr), .reg_write_data(reg_write_data),
    .out_valid(out_valid), .out_ready(out_ready), .rs_data(rs_data), .rt_data(rt_data),
    .out_dest_addr(out_dest_addr), .out_dest_en(out_dest_en), .hazard(hazard)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_mem[i]  = 32'd0;
      m_pend[i] = 1'b0;
    end
    m_ov = 1'b0; m_de = 1'b0; m_rs = 32'd0; m_rt = 32'd0; m_da = 5'd0;
  endtask

  function automatic bit m_busy(input logic [4:0] a);
    bit resolving;
    resolving = BYP && reg_write_to_file && (reg_write_addr == a);
    return (a != 5'd0) && m_pend[a] && !resolving;
  endfunction

  function automatic bit m_hz();
    return in_valid && ((rs_used && m_busy(rs_addr)) || (rt_used && m_busy(rt_addr)) ||
                        (dest_en && m_busy(dest_addr)));
  endfunction

  function automatic bit m_rdy();
    return !stall && !m_hz() && (!m_ov || out_ready);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (BYP && reg_write_to_file && reg_write_addr != 5'd0 && reg_write_addr == a)
      return reg_write_data;
    return m_mem[a];
  endfunction

  task automatic model_update();
    bit acc, wb;
    if (!rst) begin
      model_reset();
    end else begin
      acc = in_valid && m_rdy();
      wb  = reg_write_to_file && (reg_write_addr != 5'd0);
      if (!stall) begin
        if (acc) begin
          m_rs = m_read(rs_addr);
          m_rt = m_read(rt_addr);
          m_da = dest_addr;
          m_de = dest_en;
          m_ov = 1'b1;
        end else if (out_ready) begin
          m_ov = 1'b0;
        end
      end
      if (wb) begin
        m_mem[reg_write_addr]  = reg_write_data;
        m_pend[reg_write_addr] = 1'b0;
      end
      if (acc && dest_en && dest_addr != 5'd0) m_pend[dest_addr] = 1'b1;
    end
  endtask

  task automatic compare_all();
    if (!rst) model_reset();
    chk("hazard",    {31'd0, hazard},      {31'd0, m_hz()});
    chk("in_ready",  {31'd0, in_ready},    {31'd0, m_rdy()});
    chk("out_valid", {31'd0, out_valid},   {31'd0, m_ov});
    chk("rs_data",   rs_data,              m_rs);
    chk("rt_data",   rt_data,              m_rt);
    chk("dest_addr", {27'd0, out_dest_addr}, {27'd0, m_da});
    chk("dest_en",   {31'd0, out_dest_en}, {31'd0, m_de});
  endtask

  // inputs are already applied; compare mid-cycle, then advance the model on the edge
  task automatic cyc();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    stall = 0; in_valid = 0; rs_addr = 0; rt_addr = 0; rs_used = 0; rt_used = 0;
    dest_addr = 0; dest_en = 0; reg_write_to_file = 0; reg_write_addr = 0;
    reg_write_data = 0; out_ready = 1;
  endtask

  task automatic issue(input logic [4:0] rs, input logic [4:0] rt, input logic ru,
                       input logic tu, input logic [4:0] d, input logic de);
    in_valid = 1; rs_addr = rs; rt_addr = rt; rs_used = ru; rt_used = tu;
    dest_addr = d; dest_en = de;
  endtask

  task automatic wb(input logic en, input logic [4:0] a, input logic [31:0] d);
    reg_write_to_file = en; reg_write_addr = a; reg_write_data = d;
  endtask

  initial begin
    model_reset();
    idle_inputs();
    rst = 1;
    #1 rst = 0;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_rs_data", rs_data, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_hazard", {31'd0, hazard}, 32'd0);
    cyc(); cyc();
    rst = 1;

    // write r5 then read it
    wb(1, 5'd5, 32'h1234_5678);
    cyc();
    wb(0, 0, 0);
    issue(5'd5, 5'd0, 1, 1, 5'd0, 0);
    #1 chk("r5_in_ready", {31'd0, in_ready}, 32'd1);
    cyc();
    chk("r5_out_valid", {31'd0, out_valid}, 32'd1);
    chk("r5_rs_data", rs_data, 32'h1234_5678);
    chk("r5_rt_data", rt_data, 32'd0);

    // RAW on r7
    issue(5'd0, 5'd0, 0, 0, 5'd7, 1);
    cyc();
    issue(5'd7, 5'd0, 1, 0, 5'd0, 0);
    #1 chk("raw_hazard", {31'd0, hazard}, 32'd1);
    chk("raw_in_ready", {31'd0, in_ready}, 32'd0);
    cyc();
    wb(1, 5'd7, 32'hA5A5_A5A5);
    #1 chk("raw_wb_hazard", {31'd0, hazard}, BYP ? 32'd0 : 32'd1);
    cyc();
    wb(0, 0, 0);
    if (!BYP) begin
      chk("raw_gap_valid", {31'd0, out_valid}, 32'd0);
      #1 chk("raw_late_ready", {31'd0, in_ready}, 32'd1);
      cyc();
    end
    chk("raw_out_valid", {31'd0, out_valid}, 32'd1);
    chk("raw_rs_data", rs_data, 32'hA5A5_A5A5);
    in_valid = 0;
    cyc();

    // r0 writes are dropped and r0 never becomes busy
    wb(1, 5'd0, 32'hFFFF_FFFF);
    cyc();
    wb(0, 0, 0);
    issue(5'd0, 5'd0, 1, 1, 5'd0, 1);
    #1 chk("r0_hazard", {31'd0, hazard}, 32'd0);
    cyc();
    chk("r0_rs_data", rs_data, 32'd0);
    #1 chk("r0_hazard2", {31'd0, hazard}, 32'd0);
    chk("r0_in_ready2", {31'd0, in_ready}, 32'd1);
    cyc();
    in_valid = 0;
    cyc();

    // backpressure hold
    issue(5'd5, 5'd0, 1, 0, 5'd0, 0);
    cyc();
    out_ready = 0;
    issue(5'd7, 5'd0, 1, 0, 5'd0, 0);
    for (int k = 0; k < 3; k++) begin
      #1 chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      cyc();
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_rs_hold", rs_data, 32'h1234_5678);
    end
    out_ready = 1;
    #1 chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
    cyc();
    chk("bp_new_rs", rs_data, 32'hA5A5_A5A5);

    // reset with an outstanding producer of r9
    issue(5'd0, 5'd0, 0, 0, 5'd9, 1);
    cyc();
    in_valid = 0; out_ready = 0;
    cyc();
    chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    rst = 0;
    #1 chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("async_rst_rs", rs_data, 32'd0);
    out_ready = 1;
    issue(5'd9, 5'd0, 1, 0, 5'd0, 0);
    chk("async_rst_hazard", {31'd0, hazard}, 32'd0);
    cyc();
    rst = 1;
    #1 chk("post_rst_ready", {31'd0, in_ready}, 32'd1);
    cyc();
    chk("post_rst_valid", {31'd0, out_valid}, 32'd1);
    chk("post_rst_rs", rs_data, 32'd0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      stall             = ($urandom_range(0, 9) < 2);
      in_valid          = ($urandom_range(0, 9) < 7);
      rs_addr           = 5'($urandom_range(0, 7));
      rt_addr           = 5'($urandom_range(0, 7));
      rs_used           = 1'($urandom_range(0, 1));
      rt_used           = 1'($urandom_range(0, 1));
      dest_addr         = 5'($urandom_range(0, 7));
      dest_en           = 1'($urandom_range(0, 1));
      reg_write_to_file = ($urandom_range(0, 9) < 4);
      reg_write_addr    = 5'($urandom_range(0, 7));
      reg_write_data    = $urandom;
      out_ready         = ($urandom_range(0, 9) < 7);
      if (n % 997 == 500) rst = 0;
      cyc();
      rst = 1;
    end
    idle_inputs();
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
